// File: rtl/mips_state_ctrl_pkg.sv
// mips_pkg: sequencer state encoding shared with the decoder, plus the bus byte-swap helper.
package mips_pkg;
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
endpackage

// File: rtl/mips_state_ctrl_if.sv
// mips_state_ctrl_if: Avalon read side and decoder handshake of the instruction sequencer.
interface mips_state_ctrl_if;
  import mips_pkg::*;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        halt_req;
  logic        extra;
  logic        mem_req;
  state_t      state;
  logic [31:0] instruction;
  logic        active;
  logic        bus_error;
  modport master (
    input  waitrequest, readdata, halt_req, extra, mem_req,
    output state, instruction, active, bus_error
  );
  modport slave (
    output waitrequest, readdata, halt_req, extra, mem_req,
    input  state, instruction, active, bus_error
  );
endinterface

// File: rtl/mips_state_ctrl_wait_watchdog.sv
// mips_wait_watchdog: counts consecutive stall cycles; expired fires on the stall cycle that reaches WAIT_TIMEOUT.
module mips_wait_watchdog #(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic stall,
  output logic expired
);
  generate
    if (WAIT_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(WAIT_TIMEOUT + 1);
      logic [W-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= (clr || !stall) ? '0 : (r_cnt == W'(WAIT_TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
      // Combinational so HALT is taken on the very edge that ends the WAIT_TIMEOUT-th stall cycle.
      assign expired = stall && (r_cnt >= W'(WAIT_TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/mips_state_ctrl.sv
// mips_state_ctrl: FETCH/EXEC1/EXEC2/HALT sequencer and IR for the multicycle MIPS core.
// Optional perf counters (cycle_count, instr_count) are enabled by defining MIPS_STATE_PERF_EN.
module mips_state_ctrl
  import mips_pkg::*;
#(
  parameter int BYTE_SWAP    = 1,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_state_ctrl_if.master bus
`ifdef MIPS_STATE_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
`endif
);
  state_t      r_state, w_next;
  logic [31:0] r_ir;
  logic        r_bus_error;
  logic        w_stall, w_expired;
  assign w_stall = bus.waitrequest && (r_state == FETCH || (r_state == EXEC1 && bus.mem_req));
  mips_wait_watchdog #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr(w_next != r_state), .stall(w_stall), .expired(w_expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= FETCH;
      r_ir        <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_bus_error <= r_bus_error | w_expired;
      if (r_state == FETCH && w_next == EXEC1)
        r_ir <= (BYTE_SWAP != 0) ? bswap32(bus.readdata) : bus.readdata;
    end
  // Watchdog expiry overrides every other transition; halt_req beats a completing fetch.
  always_comb
    w_next = w_expired ? HALT :
             r_state == FETCH ? (bus.halt_req ? HALT : bus.waitrequest ? FETCH : EXEC1) :
             r_state == EXEC1 ? ((bus.mem_req && bus.waitrequest) ? EXEC1 : bus.extra ? EXEC2 : FETCH) :
             r_state == EXEC2 ? FETCH : HALT;
  always_comb begin
    bus.state       = r_state;
    bus.instruction = r_ir;
    bus.active      = r_state != HALT;
    bus.bus_error   = r_bus_error;
  end
`ifdef MIPS_STATE_PERF_EN
  logic [CNT_W-1:0] r_cyc, r_ins;
  logic             w_retire;
  assign w_retire = (r_state == EXEC1 || r_state == EXEC2) && w_next == FETCH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if (r_state != HALT) r_cyc <= r_cyc + 1'b1;
      if (w_retire) r_ins <= r_ins + 1'b1;
    end
  assign cycle_count = r_cyc;
  assign instr_count = r_ins;
`endif
endmodule

// File: tb/tb_mips_state_ctrl.sv
// tb_mips_state_ctrl: directed scenarios plus randomized run against a rule-level reference model.
module tb_mips_state_ctrl;
  localparam int TO = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  mips_state_ctrl_if bus();
`ifdef MIPS_STATE_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif
  mips_state_ctrl #(.BYTE_SWAP(1), .WAIT_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef MIPS_STATE_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );
  int n_cmp = 0, n_bad = 0;
  int m_state, m_wait;
  logic [31:0] m_ir, m_cyc, m_ins;
  logic m_err;
  task automatic drive(input logic h, input logic w, input logic e, input logic m, input logic [31:0] d);
    bus.halt_req = h; bus.waitrequest = w; bus.extra = e; bus.mem_req = m; bus.readdata = d;
  endtask
  task automatic model_reset;
    m_state = 0; m_wait = 0; m_ir = 0; m_err = 0; m_cyc = 0; m_ins = 0;
  endtask
  // One clock: model applies the sequencing rules to the inputs seen at the edge.
  task automatic cycle;
    bit stall;
    int nxt;
    @(posedge clk);
    stall = bus.waitrequest && (m_state == 0 || (m_state == 1 && bus.mem_req));
    case (m_state)
      0:       nxt = bus.halt_req ? 3 : bus.waitrequest ? 0 : 1;
      1:       nxt = (bus.mem_req && bus.waitrequest) ? 1 : bus.extra ? 2 : 0;
      2:       nxt = 0;
      default: nxt = 3;
    endcase
    if (stall && m_wait + 1 >= TO) begin nxt = 3; m_err = 1; end
    m_wait = (stall && nxt == m_state) ? m_wait + 1 : 0;
    if (m_state != 3) m_cyc++;
    if ((m_state == 1 || m_state == 2) && nxt == 0) m_ins++;
    if (m_state == 0 && nxt == 1)
      for (int b = 0; b < 4; b++) m_ir[8*b +: 8] = bus.readdata[8*(3-b) +: 8];
    m_state = nxt;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst_n = 0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset;
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", bus.state); end
    n_cmp++; if (bus.instruction !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h want 0", bus.instruction); end
    n_cmp++; if (bus.active !== 1'b1) begin n_bad++; $display("FAIL reset_active: got %b want 1", bus.active); end
    n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.bus_error); end
`ifdef MIPS_STATE_PERF_EN
    n_cmp++; if (cycle_count !== 0 || instr_count !== 0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_count, instr_count); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_byteswap;
    drive(0, 0, 0, 0, 32'h78563412);
    cycle();
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL swap_state: got %b want 01", bus.state); end
    n_cmp++; if (bus.instruction !== 32'h12345678) begin n_bad++; $display("FAIL swap_ir: got %h want 12345678", bus.instruction); end
    drive(0, 0, 0, 0, 32'h0);
    cycle();
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL swap_retire: got %b want 00", bus.state); end
  endtask
  task automatic test_fetch_wait;
    drive(0, 1, 0, 0, 32'hdeadbeef);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (bus.state !== 2'b00 || bus.instruction !== 32'h12345678) begin
        n_bad++; $display("FAIL fwait_%0d: got %b/%h want 00/12345678", i, bus.state, bus.instruction); end
    end
    drive(0, 0, 0, 0, 32'hdeadbeef);
    cycle();
    n_cmp++; if (bus.state !== 2'b01 || bus.instruction !== 32'hefbeadde) begin
      n_bad++; $display("FAIL fwait_done: got %b/%h want 01/efbeadde", bus.state, bus.instruction); end
  endtask
  task automatic test_exec_wait;
    drive(0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL ewait_%0d: got %b want 01", i, bus.state); end
    end
    drive(0, 0, 1, 1, 0);
    cycle();
    n_cmp++; if (bus.state !== 2'b10) begin n_bad++; $display("FAIL ewait_exec2: got %b want 10", bus.state); end
    drive(0, 0, 0, 0, 0);
    cycle();
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL ewait_fetch: got %b want 00", bus.state); end
  endtask
  task automatic test_async_reset;
    drive(0, 0, 0, 0, 32'h44332211);
    cycle();
    drive(0, 0, 1, 0, 0);
    cycle();
    n_cmp++; if (bus.state !== 2'b10) begin n_bad++; $display("FAIL areset_pre: got %b want 10", bus.state); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (bus.state !== 2'b00 || bus.instruction !== 32'h0 || bus.bus_error !== 1'b0) begin
      n_bad++; $display("FAIL areset_now: got %b/%h/%b want 00/0/0", bus.state, bus.instruction, bus.bus_error); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_halt;
    drive(0, 0, 0, 0, 32'h0dd0baab);
    cycle();
    cycle();
    drive(1, 0, 0, 0, 32'hcafef00d);
    cycle();
    n_cmp++; if (bus.state !== 2'b11 || bus.active !== 1'b0) begin
      n_bad++; $display("FAIL halt_enter: got %b/%b want 11/0", bus.state, bus.active); end
    n_cmp++; if (bus.instruction !== 32'habbad00d) begin n_bad++; $display("FAIL halt_ir: got %h want abbad00d", bus.instruction); end
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      cycle();
      n_cmp++; if (bus.state !== 2'b11 || bus.instruction !== 32'habbad00d) begin
        n_bad++; $display("FAIL halt_hold_%0d: got %b/%h want 11/abbad00d", i, bus.state, bus.instruction); end
`ifdef MIPS_STATE_PERF_EN
      n_cmp++; if (cycle_count !== m_cyc || instr_count !== m_ins) begin
        n_bad++; $display("FAIL halt_cnt_%0d: got %0d/%0d want %0d/%0d", i, cycle_count, instr_count, m_cyc, m_ins); end
`endif
    end
  endtask
  task automatic test_timeout;
    do_reset();
    drive(0, 1, 0, 0, 0);
    for (int i = 1; i < TO; i++) begin
      cycle();
      n_cmp++; if (bus.state !== 2'b00 || bus.bus_error !== 1'b0) begin
        n_bad++; $display("FAIL wd_early_%0d: got %b/%b want 00/0", i, bus.state, bus.bus_error); end
    end
    cycle();
    n_cmp++; if (bus.state !== 2'b11 || bus.bus_error !== 1'b1) begin
      n_bad++; $display("FAIL wd_fire: got %b/%b want 11/1", bus.state, bus.bus_error); end
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();
    n_cmp++; if (bus.bus_error !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b want 1", bus.bus_error); end
  endtask
  task automatic test_random;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 3 && $urandom_range(3) == 0) do_reset();
      drive($urandom_range(59) == 0, $urandom_range(9) < 4, 1'($urandom), 1'($urandom), $urandom);
      cycle();
      n_cmp++; if (bus.state !== 2'(m_state) || bus.instruction !== m_ir || bus.bus_error !== m_err || bus.active !== (m_state != 3)) begin
        n_bad++; $display("FAIL rand_%0d: got st=%b ir=%h err=%b act=%b want st=%0d ir=%h err=%b", i,
                          bus.state, bus.instruction, bus.bus_error, bus.active, m_state, m_ir, m_err); end
`ifdef MIPS_STATE_PERF_EN
      n_cmp++; if (cycle_count !== m_cyc || instr_count !== m_ins) begin
        n_bad++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, cycle_count, instr_count, m_cyc, m_ins); end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_byteswap();
    test_fetch_wait();
    test_exec_wait();
    test_async_reset();
    test_halt();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
